// File: rtl/acq_pkg.sv
// Shared types and helpers for the acquisition sequencer.
package acq_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE    = 3'd0,
        ST_READY   = 3'd1,
        ST_TX_REQ  = 3'd2,
        ST_DELAY   = 3'd3,
        ST_CAPTURE = 3'd4
    } acq_state_e;

    function automatic int packed_w(input int num_ch, input int sample_w);
        return num_ch * sample_w;
    endfunction

endpackage

// File: rtl/acq_down_counter.sv
// Loadable down-counter that saturates at zero and flags the terminal count.
module acq_down_counter #(
    parameter int W = 16
) (
    input  logic         adc_data_clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    localparam logic [W-1:0] ONE = W'(1);

    logic [W-1:0] count;

    always_ff @(posedge adc_data_clk) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - ONE;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/acq_sequencer.sv
// ADC acquisition sequencer: DAC burst handshake, post-TX delay, N-sample capture, multi-shot.
//
// state   | meaning
// IDLE    | system not ready (lock/alignment/FIFO)
// READY   | armed, waiting for acq_start
// TX_REQ  | DAC burst requested, waiting for tx_done or timeout
// DELAY   | post-TX settling delay
// CAPTURE | writing samples into the capture FIFO
module acq_sequencer
    import acq_pkg::*;
#(
    parameter int NUM_CH     = 2,
    parameter int SAMPLE_W   = 16,
    parameter int CNT_W      = 32,
    parameter int DLY_W      = 16,
    parameter int SHOT_W     = 8,
    parameter int TX_TIMEOUT = 65535
) (
    input  logic                                    adc_data_clk,
    input  logic                                    reset,
    input  logic [CNT_W-1:0]                        cfg_num_samples,
    input  logic [DLY_W-1:0]                        cfg_delay,
    input  logic [SHOT_W-1:0]                       cfg_num_shots,
    input  logic                                    acq_start,
    input  logic                                    acq_abort,
    input  logic                                    sys_locked,
    input  logic                                    adc_data_valid,
    input  logic                                    fifo_busy,
    input  logic                                    fifo_prog_full,
    input  logic [packed_w(NUM_CH, SAMPLE_W)-1:0]   adc_data,
    input  logic                                    tx_done,
    output logic                                    tx_en,
    output logic                                    fifo_wr_en,
    output logic [packed_w(NUM_CH, SAMPLE_W)-1:0]   fifo_din,
    output logic                                    busy,
    output logic                                    acq_done,
    output logic                                    overflow,
    output logic                                    tx_timeout_err,
    output logic [SHOT_W-1:0]                       shot_idx,
    output logic [STATE_W-1:0]                      state_dbg
);

    localparam int                TMO_W    = $clog2(TX_TIMEOUT + 1);
    localparam logic [TMO_W-1:0]  TMO_LOAD = TMO_W'(TX_TIMEOUT);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [DLY_W-1:0]  DLY_ONE  = DLY_W'(1);
    localparam logic [SHOT_W-1:0] SHOT_ONE = SHOT_W'(1);

    acq_state_e state, state_nxt;

    logic [CNT_W-1:0]  smp_sh;
    logic [DLY_W-1:0]  dly_sh;
    logic [SHOT_W-1:0] shot_last;

    logic tx_en_nxt, wr_en_nxt, done_nxt, ovf_nxt, tmo_err_nxt;
    logic [SHOT_W-1:0] shot_nxt;
    logic latch_cfg, enter_tx, enter_cap, dly_load, shot_end;
    logic ready_ok, stall;
    logic tmo_zero, dly_zero, smp_zero;

    assign ready_ok = sys_locked & adc_data_valid & ~fifo_busy & ~fifo_prog_full;
    assign stall    = fifo_prog_full | fifo_busy;

    always_ff @(posedge adc_data_clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        wr_en_nxt   = 1'b0;
        done_nxt    = 1'b0;
        ovf_nxt     = overflow;
        tmo_err_nxt = tx_timeout_err;
        shot_nxt    = shot_idx;
        latch_cfg   = 1'b0;
        enter_tx    = 1'b0;
        enter_cap   = 1'b0;
        dly_load    = 1'b0;
        shot_end    = 1'b0;

        case (state)
            ST_IDLE: begin
                if (ready_ok) state_nxt = ST_READY;
            end
            ST_READY: begin
                if (acq_abort || !ready_ok) begin
                    state_nxt = ST_IDLE;
                end else if (acq_start) begin
                    latch_cfg   = 1'b1;
                    ovf_nxt     = 1'b0;
                    tmo_err_nxt = 1'b0;
                    shot_nxt    = '0;
                    enter_tx    = 1'b1;
                end
            end
            ST_TX_REQ: begin
                if (acq_abort) begin
                    state_nxt = ST_IDLE;
                end else if (tmo_zero) begin
                    tmo_err_nxt = 1'b1;
                    state_nxt   = ST_IDLE;
                end else if (tx_done) begin
                    if (dly_sh != '0) begin
                        dly_load  = 1'b1;
                        state_nxt = ST_DELAY;
                    end else if (smp_sh != '0) begin
                        enter_cap = 1'b1;
                    end else begin
                        shot_end = 1'b1;
                    end
                end
            end
            ST_DELAY: begin
                if (acq_abort) begin
                    state_nxt = ST_IDLE;
                end else if (dly_zero) begin
                    if (smp_sh != '0) enter_cap = 1'b1;
                    else              shot_end  = 1'b1;
                end
            end
            ST_CAPTURE: begin
                if (acq_abort) begin
                    state_nxt = ST_IDLE;
                end else begin
                    // a stalled sample is dropped but still consumes its slot
                    wr_en_nxt = ~stall;
                    if (stall) ovf_nxt = 1'b1;
                    if (smp_zero) shot_end = 1'b1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase

        if (shot_end) begin
            if (shot_idx < shot_last) begin
                shot_nxt = shot_idx + SHOT_ONE;
                enter_tx = 1'b1;
            end else begin
                done_nxt  = 1'b1;
                state_nxt = ST_IDLE;
            end
        end
        if (enter_tx)  state_nxt = ST_TX_REQ;
        if (enter_cap) state_nxt = ST_CAPTURE;

        // request is raised one cycle after entering TX_REQ and dropped on exit
        tx_en_nxt = (state == ST_TX_REQ) && (state_nxt == ST_TX_REQ) && !enter_tx;
    end

    always_ff @(posedge adc_data_clk) begin
        if (reset) begin
            tx_en          <= 1'b0;
            fifo_wr_en     <= 1'b0;
            fifo_din       <= '0;
            acq_done       <= 1'b0;
            overflow       <= 1'b0;
            tx_timeout_err <= 1'b0;
            shot_idx       <= '0;
            smp_sh         <= '0;
            dly_sh         <= '0;
            shot_last      <= '0;
        end else begin
            tx_en          <= tx_en_nxt;
            fifo_wr_en     <= wr_en_nxt;
            acq_done       <= done_nxt;
            overflow       <= ovf_nxt;
            tx_timeout_err <= tmo_err_nxt;
            shot_idx       <= shot_nxt;
            if (state == ST_CAPTURE) fifo_din <= adc_data;
            if (latch_cfg) begin
                smp_sh    <= cfg_num_samples;
                dly_sh    <= cfg_delay;
                shot_last <= (cfg_num_shots == '0) ? '0 : cfg_num_shots - SHOT_ONE;
            end
        end
    end

    acq_down_counter #(.W(TMO_W)) u_tmo_cnt (
        .adc_data_clk (adc_data_clk),
        .reset        (reset),
        .load         (enter_tx),
        .load_val     (TMO_LOAD),
        .dec          (state == ST_TX_REQ),
        .zero         (tmo_zero)
    );

    acq_down_counter #(.W(DLY_W)) u_dly_cnt (
        .adc_data_clk (adc_data_clk),
        .reset        (reset),
        .load         (dly_load),
        .load_val     (dly_sh - DLY_ONE),
        .dec          (state == ST_DELAY),
        .zero         (dly_zero)
    );

    acq_down_counter #(.W(CNT_W)) u_smp_cnt (
        .adc_data_clk (adc_data_clk),
        .reset        (reset),
        .load         (enter_cap),
        .load_val     (smp_sh - CNT_ONE),
        .dec          (state == ST_CAPTURE),
        .zero         (smp_zero)
    );

    assign busy      = (state != ST_IDLE) && (state != ST_READY);
    assign state_dbg = state;

endmodule

// File: tb/tb_acq_sequencer.sv
// Directed bench for acq_sequencer: nominal, multi-shot, backpressure, timeout, abort, gating, reset.
module tb_acq_sequencer;

    localparam int NUM_CH     = 2;
    localparam int SAMPLE_W   = 16;
    localparam int CNT_W      = 32;
    localparam int DLY_W      = 16;
    localparam int SHOT_W     = 8;
    localparam int TX_TIMEOUT = 20;
    localparam int DW         = NUM_CH * SAMPLE_W;

    logic              adc_data_clk = 1'b0;
    logic              reset = 1'b1;
    logic [CNT_W-1:0]  cfg_num_samples = '0;
    logic [DLY_W-1:0]  cfg_delay = '0;
    logic [SHOT_W-1:0] cfg_num_shots = '0;
    logic              acq_start = 1'b0;
    logic              acq_abort = 1'b0;
    logic              sys_locked = 1'b0;
    logic              adc_data_valid = 1'b0;
    logic              fifo_busy = 1'b0;
    logic              fifo_prog_full = 1'b0;
    logic [DW-1:0]     adc_data = '0;
    logic              tx_done = 1'b0;
    logic              tx_en;
    logic              fifo_wr_en;
    logic [DW-1:0]     fifo_din;
    logic              busy;
    logic              acq_done;
    logic              overflow;
    logic              tx_timeout_err;
    logic [SHOT_W-1:0] shot_idx;
    logic [2:0]        state_dbg;

    acq_sequencer #(
        .NUM_CH(NUM_CH), .SAMPLE_W(SAMPLE_W), .CNT_W(CNT_W),
        .DLY_W(DLY_W), .SHOT_W(SHOT_W), .TX_TIMEOUT(TX_TIMEOUT)
    ) dut (
        .adc_data_clk    (adc_data_clk),
        .reset           (reset),
        .cfg_num_samples (cfg_num_samples),
        .cfg_delay       (cfg_delay),
        .cfg_num_shots   (cfg_num_shots),
        .acq_start       (acq_start),
        .acq_abort       (acq_abort),
        .sys_locked      (sys_locked),
        .adc_data_valid  (adc_data_valid),
        .fifo_busy       (fifo_busy),
        .fifo_prog_full  (fifo_prog_full),
        .adc_data        (adc_data),
        .tx_done         (tx_done),
        .tx_en           (tx_en),
        .fifo_wr_en      (fifo_wr_en),
        .fifo_din        (fifo_din),
        .busy            (busy),
        .acq_done        (acq_done),
        .overflow        (overflow),
        .tx_timeout_err  (tx_timeout_err),
        .shot_idx        (shot_idx),
        .state_dbg       (state_dbg)
    );

    always #5 adc_data_clk = ~adc_data_clk;

    int checks = 0;
    int failures = 0;

    // event monitor: counts strobes and checks fifo_din against the sample the DUT saw
    logic [DW-1:0] adc_prev = '0;
    logic          tx_prev = 1'b0;
    int wr_cnt = 0, done_cnt = 0, tx_cnt = 0, din_bad = 0, din_seen = 0;

    always @(posedge adc_data_clk) adc_prev <= adc_data;

    always @(negedge adc_data_clk) begin
        if (fifo_wr_en === 1'b1) begin
            wr_cnt++;
            din_seen++;
            if (fifo_din !== adc_prev) din_bad++;
        end
        if (acq_done === 1'b1) done_cnt++;
        if (tx_en === 1'b1 && tx_prev !== 1'b1) tx_cnt++;
        tx_prev = tx_en;
    end

    logic [15:0] cyc = '0;
    int wr0, done0, tx0, bad0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge adc_data_clk);
        #1;
        cyc++;
        adc_data = {cyc, ~cyc};
    endtask

    task automatic mark();
        wr0 = wr_cnt; done0 = done_cnt; tx0 = tx_cnt; bad0 = din_bad;
    endtask

    task automatic start_acq(input int n, input int d, input int s);
        cfg_num_samples = CNT_W'(n);
        cfg_delay       = DLY_W'(d);
        cfg_num_shots   = SHOT_W'(s);
        mark();
        acq_start = 1'b1;
        step();
        acq_start = 1'b0;
    endtask

    task automatic wait_tx(input string tag);
        int n = 0;
        while (tx_en !== 1'b1 && n < 60) begin step(); n++; end
        chk(tag, 64'(tx_en), 64'(1));
    endtask

    task automatic wait_ready(input string tag);
        int n = 0;
        while (state_dbg !== 3'd1 && n < 300) begin step(); n++; end
        chk(tag, 64'(state_dbg), 64'(1));
    endtask

    task automatic do_shot(input int lat, input int dly, input int k);
        int n = 0;
        wait_tx("tx_en_rise");
        chk("shot_idx", 64'(shot_idx), 64'(k));
        repeat (lat - 1) step();
        tx_done = 1'b1;
        step();
        tx_done = 1'b0;
        chk("tx_en_drop", 64'(tx_en), 64'(0));
        while (fifo_wr_en !== 1'b1 && n < 40) begin step(); n++; end
        chk("first_write_gap", 64'(n), 64'(dly + 1));
    endtask

    initial begin
        int hi;

        // reset state
        sys_locked = 1'b1;
        adc_data_valid = 1'b1;
        repeat (3) step();
        chk("rst_state", 64'(state_dbg), 64'(0));
        chk("rst_tx_en", 64'(tx_en), 64'(0));
        chk("rst_wr_en", 64'(fifo_wr_en), 64'(0));
        chk("rst_din", 64'(fifo_din), 64'(0));
        chk("rst_flags", 64'({busy, acq_done, overflow, tx_timeout_err}), 64'(0));
        chk("rst_shot", 64'(shot_idx), 64'(0));
        reset = 1'b0;
        step();
        chk("idle_to_ready", 64'(state_dbg), 64'(1));

        // abort beats start in READY
        acq_start = 1'b1; acq_abort = 1'b1;
        step();
        acq_start = 1'b0; acq_abort = 1'b0;
        chk("abort_start_state", 64'(state_dbg), 64'(0));
        step();
        chk("abort_start_tx", 64'(tx_en), 64'(0));
        wait_ready("abort_start_rearm");

        // nominal: 8 samples, no delay, one shot
        start_acq(8, 0, 1);
        chk("nom_tx_req", 64'(state_dbg), 64'(2));
        chk("nom_busy", 64'(busy), 64'(1));
        chk("nom_tx_late", 64'(tx_en), 64'(0));
        do_shot(5, 0, 0);
        wait_ready("nom_end");
        chk("nom_writes", 64'(wr_cnt - wr0), 64'(8));
        chk("nom_done", 64'(done_cnt - done0), 64'(1));
        chk("nom_tx_pulses", 64'(tx_cnt - tx0), 64'(1));
        chk("nom_din", 64'(din_bad - bad0), 64'(0));

        // multi-shot with delay
        start_acq(4, 3, 3);
        do_shot(5, 3, 0);
        do_shot(5, 3, 1);
        do_shot(5, 3, 2);
        wait_ready("multi_end");
        chk("multi_writes", 64'(wr_cnt - wr0), 64'(12));
        chk("multi_tx_pulses", 64'(tx_cnt - tx0), 64'(3));
        chk("multi_done", 64'(done_cnt - done0), 64'(1));
        chk("multi_din", 64'(din_bad - bad0), 64'(0));

        // backpressure on samples 3-4 of 10
        start_acq(10, 0, 1);
        wait_tx("bp_tx");
        repeat (4) step();
        tx_done = 1'b1; step(); tx_done = 1'b0;
        repeat (2) step();
        fifo_prog_full = 1'b1;
        repeat (2) step();
        fifo_prog_full = 1'b0;
        wait_ready("bp_end");
        chk("bp_writes", 64'(wr_cnt - wr0), 64'(8));
        chk("bp_overflow", 64'(overflow), 64'(1));
        chk("bp_done", 64'(done_cnt - done0), 64'(1));

        // tx timeout
        start_acq(4, 0, 1);
        chk("ovf_cleared", 64'(overflow), 64'(0));
        wait_tx("tmo_tx");
        hi = 1;
        while (tx_en === 1'b1 && hi < 100) begin
            step();
            if (tx_en === 1'b1) hi++;
        end
        chk("tmo_tx_cycles", 64'(hi), 64'(TX_TIMEOUT));
        chk("tmo_err", 64'(tx_timeout_err), 64'(1));
        chk("tmo_state", 64'(state_dbg), 64'(0));
        wait_ready("tmo_rearm");
        chk("tmo_writes", 64'(wr_cnt - wr0), 64'(0));
        chk("tmo_done", 64'(done_cnt - done0), 64'(0));

        // abort after 5 of 100 samples
        start_acq(100, 0, 1);
        chk("tmo_err_cleared", 64'(tx_timeout_err), 64'(0));
        wait_tx("abort_tx");
        repeat (4) step();
        tx_done = 1'b1; step(); tx_done = 1'b0;
        repeat (5) step();
        acq_abort = 1'b1;
        step();
        acq_abort = 1'b0;
        chk("abort_wr_en", 64'(fifo_wr_en), 64'(0));
        chk("abort_state", 64'(state_dbg), 64'(0));
        wait_ready("abort_rearm");
        chk("abort_writes", 64'(wr_cnt - wr0), 64'(5));
        chk("abort_done", 64'(done_cnt - done0), 64'(0));

        // start ignored while ADC not aligned
        adc_data_valid = 1'b0;
        repeat (2) step();
        chk("gate_idle", 64'(state_dbg), 64'(0));
        mark();
        acq_start = 1'b1; step(); acq_start = 1'b0;
        repeat (3) step();
        chk("gate_tx", 64'(tx_cnt - tx0), 64'(0));
        chk("gate_state", 64'(state_dbg), 64'(0));
        adc_data_valid = 1'b1;
        wait_ready("gate_rearm");

        // zero samples, shots=0 behaves as one shot
        start_acq(0, 2, 0);
        wait_tx("zero_tx");
        repeat (4) step();
        tx_done = 1'b1; step(); tx_done = 1'b0;
        wait_ready("zero_end");
        chk("zero_writes", 64'(wr_cnt - wr0), 64'(0));
        chk("zero_done", 64'(done_cnt - done0), 64'(1));
        chk("zero_tx_pulses", 64'(tx_cnt - tx0), 64'(1));

        // reset mid-operation
        start_acq(8, 0, 2);
        wait_tx("mid_rst_tx");
        reset = 1'b1;
        step();
        chk("mid_rst_tx_en", 64'(tx_en), 64'(0));
        chk("mid_rst_busy", 64'(busy), 64'(0));
        chk("mid_rst_state", 64'(state_dbg), 64'(0));
        reset = 1'b0;
        wait_ready("mid_rst_rearm");

        chk("din_seen", 64'(din_seen > 0), 64'(1));
        chk("din_total_bad", 64'(din_bad), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
